// File: rtl/pseudo_spi_rx_intf_pkg.sv
// rtl/pseudo_spi_rx_intf_pkg.sv - shared widths, rx state and scan-phase encodings
package pseudo_spi_rx_intf_pkg;

    localparam int MEM_DW = 8;
    localparam int MEM_AW = 9;
    localparam int LEN_W  = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_LOAD,
        RX_SHIFT,
        RX_WRITE,
        RX_DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        PH_P0,
        PH_P1,
        PH_P2,
        PH_P3
    } phase_t;

endpackage

// File: rtl/pseudo_spi_rx_intf_if.sv
// rtl/pseudo_spi_rx_intf_if.sv - CPU start/status, scan chain and SRAM write bundle
interface pseudo_spi_rx_intf_if
    import pseudo_spi_rx_intf_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW,
    parameter int LW = LEN_W
);
    logic          bgn;
    logic [AW-1:0] addr_bgn;
    logic [LW-1:0] data_len;
    logic          spi_si;
    logic          sclk1;
    logic          sclk2;
    logic          sel;
    logic          cen;
    logic          d_we;
    logic [AW-1:0] a;
    logic [DW-1:0] po;
    logic          spi_is_done;

    modport slave (
        input  bgn, addr_bgn, data_len, spi_si,
        output sclk1, sclk2, sel, cen, d_we, a, po, spi_is_done
    );

    modport master (
        output bgn, addr_bgn, data_len, spi_si,
        input  sclk1, sclk2, sel, cen, d_we, a, po, spi_is_done
    );
endinterface

// File: rtl/pseudo_spi_rx_intf_spi_phase_gen.sv
// rtl/pseudo_spi_rx_intf_spi_phase_gen.sv - four-phase bit-slot timer driving SCLK1/SCLK2
module pseudo_spi_rx_intf_spi_phase_gen
    import pseudo_spi_rx_intf_pkg::*;
#(
    parameter int PHASE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic run_n,
    output logic sample,
    output logic slot_end,
    output logic sclk1,
    output logic sclk2
);
    localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYC - 1);

    logic [CW-1:0] cnt, cnt_n;
    phase_t        phase, phase_n;
    logic          last;

    assign last     = (cnt == CNT_LAST);
    assign sample   = run && (phase == PH_P0) && last;
    assign slot_end = run && (phase == PH_P3) && last;

    // Outside an active slot the timer parks at P0 so the next slot starts clean.
    always_comb begin
        cnt_n   = '0;
        phase_n = PH_P0;
        if (run) begin
            if (last) begin
                phase_n = phase_t'(phase + 2'd1);
            end else begin
                cnt_n   = cnt + 1'b1;
                phase_n = phase;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PH_P0;
            sclk1 <= 1'b0;
            sclk2 <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            phase <= phase_n;
            sclk1 <= run_n && (phase_n == PH_P1);
            sclk2 <= run_n && (phase_n == PH_P3);
        end
    end
endmodule

// File: rtl/pseudo_spi_rx_intf.sv
// rtl/pseudo_spi_rx_intf.sv - scan-chain read-back: capture, shift in bytes, write to SRAM
module pseudo_spi_rx_intf
    import pseudo_spi_rx_intf_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = MEM_DW,
    parameter int MEMORY_ADDR_WIDTH = MEM_AW,
    parameter int RESERVED_DATA_LEN = LEN_W,
    parameter int PHASE_CYC         = 1
) (
    input logic                 clk,
    input logic                 rst,
    pseudo_spi_rx_intf_if.slave bus
);
    localparam int DW = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int LW = RESERVED_DATA_LEN;
    localparam int BW = $clog2(DW);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    rx_state_t     state, state_n;
    logic          bgn_q;
    logic [AW-1:0] addr_cur, addr_n;
    logic [LW-1:0] left, left_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DW-1:0] shreg, sh_n;
    logic          run, run_n, sample, slot_end;

    assign run   = (state == RX_LOAD) || (state == RX_SHIFT);
    assign run_n = (state_n == RX_LOAD) || (state_n == RX_SHIFT);

    pseudo_spi_rx_intf_spi_phase_gen #(.PHASE_CYC(PHASE_CYC)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .run_n    (run_n),
        .sample   (sample),
        .slot_end (slot_end),
        .sclk1    (bus.sclk1),
        .sclk2    (bus.sclk2)
    );

    always_comb begin
        state_n = state;
        addr_n  = addr_cur;
        left_n  = left;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        if (!bus.bgn) begin
            state_n = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!bgn_q) begin
                        addr_n  = bus.addr_bgn;
                        left_n  = bus.data_len;
                        bit_n   = '0;
                        state_n = (bus.data_len == '0) ? RX_DONE : RX_LOAD;
                    end
                end
                RX_LOAD: begin
                    if (slot_end) state_n = RX_SHIFT;
                end
                RX_SHIFT: begin
                    if (sample) sh_n = {shreg[DW-2:0], bus.spi_si};
                    if (slot_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
                            state_n = RX_WRITE;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
                RX_WRITE: begin
                    addr_n  = addr_cur + 1'b1;
                    left_n  = left - 1'b1;
                    state_n = (left == LEN_ONE) ? RX_DONE : RX_SHIFT;
                end
                RX_DONE: state_n = RX_DONE;
                default: state_n = RX_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state so each pin is clean for the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RX_IDLE;
            bgn_q           <= 1'b0;
            addr_cur        <= '0;
            left            <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            bus.sel         <= 1'b0;
            bus.cen         <= 1'b1;
            bus.d_we        <= 1'b0;
            bus.a           <= '0;
            bus.po          <= '0;
            bus.spi_is_done <= 1'b0;
        end else begin
            state           <= state_n;
            bgn_q           <= bus.bgn;
            addr_cur        <= addr_n;
            left            <= left_n;
            bit_cnt         <= bit_n;
            shreg           <= sh_n;
            bus.sel         <= (state_n == RX_LOAD);
            bus.cen         <= (state_n != RX_WRITE);
            bus.d_we        <= (state_n == RX_WRITE);
            bus.a           <= (state_n == RX_WRITE) ? addr_cur : '0;
            bus.po          <= (state_n == RX_WRITE) ? shreg : '0;
            bus.spi_is_done <= (state_n == RX_DONE);
        end
    end
endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// tb/tb_pseudo_spi_rx_intf.sv - directed bench for pseudo_spi_rx_intf at PHASE_CYC 1 and 3
module tb_pseudo_spi_rx_intf;
    localparam logic [22:0] IDLE_OUTS = 23'h080000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_clr = 1'b1;
    logic [63:0] chain = '0;
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    int          cyc;

    always #5 clk = ~clk;

    pseudo_spi_rx_intf_if bus[2] ();

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int P = (g == 0) ? 1 : 3;

        pseudo_spi_rx_intf #(.PHASE_CYC(P)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );

        int         wr_cnt = 0, overlap = 0, bad_w = 0, sel_edges = 0;
        int         sclk_edges = 0, cen_low = 0, w1 = 0, w2 = 0;
        logic [8:0] wr_a [8];
        logic [7:0] wr_d [8];
        logic [5:0] idx = '0;
        logic       p_sel = 1'b0, p_s1 = 1'b0, p_s2 = 1'b0;

        // Scan chain model: LOAD rewinds it, each shift-slot SCLK2 pulse advances one bit.
        always @(negedge clk) begin
            if (mon_clr) begin
                wr_cnt = 0; overlap = 0; bad_w = 0; sel_edges = 0;
                sclk_edges = 0; cen_low = 0; w1 = 0; w2 = 0;
            end else begin
                if (bus[g].sclk1 && bus[g].sclk2) overlap++;
                if (bus[g].sel != p_sel) sel_edges++;
                if (bus[g].sclk1 != p_s1 || bus[g].sclk2 != p_s2) sclk_edges++;
                if (!bus[g].cen) cen_low++;
                if (bus[g].sclk1) w1++;
                else begin
                    if (p_s1 && w1 != P) bad_w++;
                    w1 = 0;
                end
                if (bus[g].sclk2) w2++;
                else begin
                    if (p_s2 && w2 != P) bad_w++;
                    w2 = 0;
                end
                if (bus[g].d_we && !bus[g].cen) begin
                    if (wr_cnt < 8) begin
                        wr_a[wr_cnt] = bus[g].a;
                        wr_d[wr_cnt] = bus[g].po;
                    end
                    wr_cnt++;
                end
            end
            if (bus[g].sel) idx = '0;
            else if (p_s2 && !bus[g].sclk2 && !p_sel) idx = idx + 6'd1;
            bus[g].spi_si = chain[6'd63 - idx];
            p_sel = bus[g].sel;
            p_s1  = bus[g].sclk1;
            p_s2  = bus[g].sclk2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] outs0();
        return {bus[0].sclk1, bus[0].sclk2, bus[0].sel, bus[0].cen, bus[0].d_we,
                bus[0].a, bus[0].po, bus[0].spi_is_done};
    endfunction

    task automatic run_to_done(input int g, input int budget, output int n);
        n = 0;
        while (n < budget && !((g == 0) ? bus[0].spi_is_done : bus[1].spi_is_done)) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        bus[0].bgn = 1'b0; bus[0].addr_bgn = '0; bus[0].data_len = '0;
        bus[1].bgn = 1'b0; bus[1].addr_bgn = '0; bus[1].data_len = '0;
        tick(2);
        chk("reset_outs", 32'(outs0()), 32'(IDLE_OUTS));
        rst = 1'b0;
        tick(1);
        chk("idle_outs", 32'(outs0()), 32'(IDLE_OUTS));

        // Two bytes at P=1; inputs changed after the latch must not matter.
        chain = {8'hA5, 8'h3C, 48'h0};
        bus[0].addr_bgn = 9'h1F0; bus[0].data_len = 8'd2;
        clear_mon();
        bus[0].bgn = 1'b1;
        tick(3);
        bus[0].addr_bgn = 9'h000; bus[0].data_len = 8'd5;
        run_to_done(0, 200, cyc);
        chk("done_lat_p1", cyc + 3, 71);
        chk("wr_cnt", gen_dut[0].wr_cnt, 2);
        chk("wr_a0", gen_dut[0].wr_a[0], 9'h1F0);
        chk("wr_d0", gen_dut[0].wr_d[0], 8'hA5);
        chk("wr_a1", gen_dut[0].wr_a[1], 9'h1F1);
        chk("wr_d1", gen_dut[0].wr_d[1], 8'h3C);
        chk("overlap_p1", gen_dut[0].overlap, 0);
        chk("width_p1", gen_dut[0].bad_w, 0);
        chk("sel_edges", gen_dut[0].sel_edges, 2);
        tick(5);
        chk("done_held", bus[0].spi_is_done, 1);
        chk("no_restart", gen_dut[0].wr_cnt, 2);
        bus[0].bgn = 1'b0;
        tick(1);
        chk("done_clear", 32'(outs0()), 32'(IDLE_OUTS));

        // Address wrap across 0x1FF.
        chain = {8'h12, 8'h34, 48'h0};
        bus[0].addr_bgn = 9'h1FF; bus[0].data_len = 8'd2;
        clear_mon();
        bus[0].bgn = 1'b1;
        run_to_done(0, 200, cyc);
        chk("wrap_lat", cyc, 71);
        chk("wrap_a0", gen_dut[0].wr_a[0], 9'h1FF);
        chk("wrap_a1", gen_dut[0].wr_a[1], 9'h000);
        chk("wrap_d0", gen_dut[0].wr_d[0], 8'h12);
        chk("wrap_d1", gen_dut[0].wr_d[1], 8'h34);
        bus[0].bgn = 1'b0;
        tick(1);

        // Zero length: straight to done, no scan activity.
        bus[0].data_len = 8'd0;
        clear_mon();
        bus[0].bgn = 1'b1;
        tick(1);
        chk("len0_done", bus[0].spi_is_done, 1);
        tick(4);
        chk("len0_sel", gen_dut[0].sel_edges, 0);
        chk("len0_sclk", gen_dut[0].sclk_edges, 0);
        chk("len0_cen", gen_dut[0].cen_low, 0);
        bus[0].bgn = 1'b0;
        tick(1);

        // Abort during bit 5 of byte 0, then restart from a fresh LOAD.
        chain = {8'hA5, 8'h3C, 48'h0};
        bus[0].addr_bgn = 9'h010; bus[0].data_len = 8'd2;
        clear_mon();
        bus[0].bgn = 1'b1;
        tick(26);
        bus[0].bgn = 1'b0;
        tick(1);
        chk("abort_outs", 32'(outs0()), 32'(IDLE_OUTS));
        tick(3);
        chk("abort_nowr", gen_dut[0].wr_cnt, 0);
        clear_mon();
        bus[0].bgn = 1'b1;
        tick(1);
        chk("restart_sel", bus[0].sel, 1);
        run_to_done(0, 200, cyc);
        chk("restart_lat", cyc + 1, 71);
        chk("restart_wr", gen_dut[0].wr_cnt, 2);
        chk("restart_a0", gen_dut[0].wr_a[0], 9'h010);
        chk("restart_d0", gen_dut[0].wr_d[0], 8'hA5);
        bus[0].bgn = 1'b0;
        tick(1);

        // Asynchronous reset in the middle of SHIFT.
        clear_mon();
        bus[0].bgn = 1'b1;
        tick(20);
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(outs0()), 32'(IDLE_OUTS));
        bus[0].bgn = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("rst_idle", 32'(outs0()), 32'(IDLE_OUTS));
        chk("rst_nowr", gen_dut[0].wr_cnt, 0);

        // PHASE_CYC=3 instance, one byte.
        chain = {8'hC3, 56'h0};
        bus[1].addr_bgn = 9'h055; bus[1].data_len = 8'd1;
        clear_mon();
        bus[1].bgn = 1'b1;
        run_to_done(1, 400, cyc);
        chk("done_lat_p3", cyc, 110);
        chk("p3_wr_cnt", gen_dut[1].wr_cnt, 1);
        chk("p3_a0", gen_dut[1].wr_a[0], 9'h055);
        chk("p3_d0", gen_dut[1].wr_d[0], 8'hC3);
        chk("overlap_p3", gen_dut[1].overlap, 0);
        chk("width_p3", gen_dut[1].bad_w, 0);
        chk("sclk_edges_p3", gen_dut[1].sclk_edges, 36);
        bus[1].bgn = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
